// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : LSU-side store FIFO with newest-match load forwarding and
//            opportunistic drain to a single-ported data memory.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            access_i,
    input  logic            write_i,
    input  logic [63:0]     addr_i,
    input  logic [63:0]     wdata_i,
    output logic [63:0]     rdata_o,
    output logic            stall_o,
    output logic            empty_o,
    output logic [PTRW:0]   count_o,
    output logic            ovf_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [63:0]     mem_addr_o,
    output logic [63:0]     mem_wdata_o,
    input  logic            mem_ready_i,
    input  logic [63:0]     mem_rdata_i
);

    localparam logic [PTRW:0] C_DEPTH = (PTRW+1)'(DEPTH);

    logic [60:0]        r_addr [DEPTH];
    logic [63:0]        r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTRW-1:0]    r_head;
    logic [PTRW-1:0]    r_tail;
    logic [PTRW:0]      r_count;
    logic               r_ovf;
    logic               r_load_d;
    logic               r_hit;
    logic [63:0]        r_fwd;
    logic [63:0]        r_hold;

    logic               w_store;
    logic               w_load;
    logic               w_full;
    logic               w_enq;
    logic               w_deq;
    logic               w_hit;
    logic [63:0]        w_fwd;
    logic               w_miss;
    logic               w_drain_req;
    logic [63:0]        w_rdata;
    logic               w_unused_addr_lsb;

    assign w_store     = access_i & write_i;
    assign w_load      = access_i & ~write_i;
    assign w_full      = (r_count == C_DEPTH);
    assign w_enq       = w_store & ~w_full;
    assign w_miss      = w_load & ~w_hit;
    assign w_drain_req = (r_count != '0) & ~w_miss;
    assign w_deq       = w_drain_req & mem_ready_i;

    assign w_unused_addr_lsb = &{1'b0, addr_i[2:0]};

    // Walk oldest-to-newest from head so the last match (newest store) wins.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[r_head + PTRW'(k)] && (r_addr[r_head + PTRW'(k)] == addr_i[63:3])) begin
                w_hit = 1'b1;
                w_fwd = r_data[r_head + PTRW'(k)];
            end
        end
    end

    // A load miss owns the port; the drain waits a cycle.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {r_addr[r_head], 3'b000};
        mem_wdata_o = r_data[r_head];
        if (w_miss) begin
            mem_req_o  = 1'b1;
            mem_addr_o = {addr_i[63:3], 3'b000};
        end else if (w_drain_req) begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
        end
    end

    always_comb begin
        w_rdata = r_hold;
        if (r_load_d) begin
            w_rdata = r_hit ? r_fwd : mem_rdata_i;
        end
    end

    // Entry payload carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= addr_i[63:3];
            r_data[r_tail] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_ovf    <= 1'b0;
            r_load_d <= 1'b0;
            r_hit    <= 1'b0;
            r_fwd    <= '0;
            r_hold   <= '0;
        end else begin
            // Enqueue and dequeue slots only coincide when count is 0 or DEPTH,
            // and neither of those allows both, so the two writes never collide.
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PTRW+1)'(1);
                2'b01:   r_count <= r_count - (PTRW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_store && w_full) begin
                r_ovf <= 1'b1;
            end
            r_load_d <= w_load;
            if (w_load) begin
                r_hit <= w_hit;
                r_fwd <= w_fwd;
            end
            if (r_load_d) begin
                r_hold <= w_rdata;
            end
        end
    end

    assign rdata_o   = w_rdata;
    assign stall_o   = w_full;
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign ovf_err_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Directed self-checking bench for store_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        access_i;
    logic        write_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        stall_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic        ovf_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [63:0] mem_rdata_i;

    int checks;
    int failures;

    logic [127:0] wr_log [$];

    store_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .access_i    (access_i),
        .write_i     (write_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .ovf_err_o   (ovf_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side write monitor: every accepted write, in order.
    always @(posedge clk) begin
        if (!rst && mem_req_o && mem_we_o && mem_ready_i) begin
            wr_log.push_back({mem_addr_o, mem_wdata_o});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        access_i    = 1'b0;
        write_i     = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
        mem_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic push_store(input logic [63:0] a, input logic [63:0] d);
        access_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = a;
        wdata_i  = d;
        tick();
        access_i = 1'b0;
        write_i  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
        checks++; if (rdata_o !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
        checks++; if (ovf_err_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_err_o); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_store(64'h100 + 64'(8*i), 64'hD000 + 64'(i));
            #1;
            checks++; if (count_o !== 3'(i+1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, i+1); end
        end
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", stall_o); end
        checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 64'h100 || mem_wdata_o !== 64'hD000)
            begin failures++; $display("FAIL full_drain_req got=req%b we%b a=%h d=%h exp=req1 we1 a=100 d=d000", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
        push_store(64'h120, 64'hEEEE);
        #1;
        checks++; if (ovf_err_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_err_o); end
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count_o); end
        checks++; if (mem_addr_o !== 64'h100) begin failures++; $display("FAIL ovf_head got=%h exp=100", mem_addr_o); end
        tick();
        checks++; if (ovf_err_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err_o); end
    endtask

    task automatic test_forward();
        do_reset();
        mem_ready_i = 1'b0;
        mem_rdata_i = 64'hDEAD_BEEF;
        push_store(64'h200, 64'hAAAA);
        push_store(64'h200, 64'hBBBB);
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL fwd_dup_count got=%0d exp=2", count_o); end
        access_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 64'h204;
        #1;
        checks++; if (mem_req_o === 1'b1 && mem_we_o === 1'b0) begin failures++; $display("FAIL fwd_no_read got=read_issued exp=no_read"); end
        tick();
        access_i = 1'b0;
        #1;
        checks++; if (rdata_o !== 64'hBBBB) begin failures++; $display("FAIL fwd_newest got=%h exp=bbbb", rdata_o); end
        mem_rdata_i = 64'h7777;
        tick();
        checks++; if (rdata_o !== 64'hBBBB) begin failures++; $display("FAIL fwd_hold got=%h exp=bbbb", rdata_o); end
    endtask

    task automatic test_load_miss();
        do_reset();
        access_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 64'h305;
        #1;
        checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 64'h300)
            begin failures++; $display("FAIL miss_req got=req%b we%b a=%h exp=req1 we0 a=300", mem_req_o, mem_we_o, mem_addr_o); end
        tick();
        access_i    = 1'b0;
        mem_rdata_i = 64'h1234;
        #1;
        checks++; if (rdata_o !== 64'h1234) begin failures++; $display("FAIL miss_rdata got=%h exp=1234", rdata_o); end
        tick();
        mem_rdata_i = 64'h9999;
        #1;
        checks++; if (rdata_o !== 64'h1234) begin failures++; $display("FAIL miss_hold got=%h exp=1234", rdata_o); end
    endtask

    task automatic test_miss_defers_drain();
        int base;
        do_reset();
        mem_ready_i = 1'b1;
        base = wr_log.size();
        push_store(64'h400, 64'h4444);
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL defer_count1 got=%0d exp=1", count_o); end
        access_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 64'h500;
        #1;
        checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 64'h500)
            begin failures++; $display("FAIL defer_read got=req%b we%b a=%h exp=req1 we0 a=500", mem_req_o, mem_we_o, mem_addr_o); end
        tick();
        access_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL defer_kept got=%0d exp=1", count_o); end
        checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 64'h400 || mem_wdata_o !== 64'h4444)
            begin failures++; $display("FAIL defer_write got=req%b we%b a=%h d=%h exp=req1 we1 a=400 d=4444", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
        tick();
        checks++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin failures++; $display("FAIL defer_drained got=cnt%0d empty%b exp=cnt0 empty1", count_o, empty_o); end
        checks++; if (wr_log.size() !== base + 1) begin failures++; $display("FAIL defer_wr_count got=%0d exp=1", wr_log.size() - base); end
        else begin
            checks++; if (wr_log[base] !== {64'h400, 64'h4444}) begin failures++; $display("FAIL defer_wr_entry got=%h exp=400/4444", wr_log[base]); end
        end
    endtask

    task automatic test_back_to_back_wrap();
        int base;
        int sent;
        int cyc;
        do_reset();
        base = wr_log.size();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_store(64'h600 + 64'(8*i), 64'hA0 + 64'(i));
        end
        mem_ready_i = 1'b1;
        sent = 4;
        cyc  = 0;
        while (sent < 8 && cyc < 30) begin
            if (!stall_o) begin
                access_i = 1'b1;
                write_i  = 1'b1;
                addr_i   = 64'h600 + 64'(8*sent);
                wdata_i  = 64'hA0 + 64'(sent);
                sent++;
            end else begin
                access_i = 1'b0;
                write_i  = 1'b0;
            end
            tick();
            cyc++;
        end
        access_i = 1'b0;
        write_i  = 1'b0;
        cyc = 0;
        while (!empty_o && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL wrap_drain_timeout got=cnt%0d exp=empty", count_o); end
        checks++; if (ovf_err_o !== 1'b0) begin failures++; $display("FAIL wrap_ovf got=%b exp=0", ovf_err_o); end
        checks++; if (wr_log.size() !== base + 8) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=8", wr_log.size() - base); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_log[base+i] !== {64'h600 + 64'(8*i), 64'hA0 + 64'(i)}) begin
                    failures++;
                    $display("FAIL wrap_order[%0d] got=%h exp=%h", i, wr_log[base+i], {64'h600 + 64'(8*i), 64'hA0 + 64'(i)});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_store(64'h700 + 64'(8*i), 64'hC0 + 64'(i));
        end
        checks++; if (count_o !== 3'd3) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=3", count_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = wr_log.size();
        mem_ready_i = 1'b1;
        #1;
        checks++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin failures++; $display("FAIL rmid_state got=cnt%0d empty%b exp=cnt0 empty1", count_o, empty_o); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rmid_mem_req got=%b exp=0", mem_req_o); end
        checks++; if (ovf_err_o !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%b exp=0", ovf_err_o); end
        tick();
        tick();
        tick();
        checks++; if (wr_log.size() !== base) begin failures++; $display("FAIL rmid_no_writes got=%0d exp=0", wr_log.size() - base); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        access_i    = 1'b0;
        write_i     = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        test_reset();
        test_fill_overflow();
        test_forward();
        test_load_miss();
        test_miss_defers_drain();
        test_back_to_back_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
